alu_unpipelined: RTL and testbench
==================================

# alu_unpipelined

16-bit single-cycle ALU for the unpipelined processor datapath, sitting between the register-file read ports and the writeback/branch logic. It computes add/subtract, rotates, shifts and bitwise logic combinationally, with optional input inversion, carry-in and signed/unsigned overflow detection. It also produces zero/sign condition flags for branch decisions. A registered copy of the result and flags is provided for use by sequential control.

## Interface
Parameters: none (datapath fixed at 16 bits).
- clk  input  1  single clock; only the registered copies use it
- rst  input  1  asynchronous, active-high reset
- A  input  16  operand A
- B  input  16  operand B; B[3:0] is the shift/rotate amount
- Cin  input  1  carry-in, used by ADD only
- Op  input  3  operation select
- invA  input  1  bitwise-invert A before the operation
- invB  input  1  bitwise-invert B before the operation
- sign  input  1  1 = signed overflow rule, 0 = unsigned
- Out  output  16  combinational result
- Ofl  output  1  combinational overflow (ADD only, else 0)
- zf  output  1  Out == 0
- gzf  output  1  Out > 0, two's complement (Out[15]==0 and Out!=0)
- lzf  output  1  Out < 0, two's complement (Out[15])
- nezf  output  1  Out != 0
- Out_r  output  16  Out registered on rising clk
- Ofl_r  output  1  Ofl registered
- flags_r  output  4  {nezf,lzf,gzf,zf} registered

## Operation
- Effective operands: a = invA ? ~A : A; b = invB ? ~B : B. Inversion applies to every Op.
- Shift amount sh = b[3:0] (0–15).
- Op encodings:
  - 000 ADD: Out = a + b + Cin, mod 2^16. Subtraction A−B is ADD with invB=1, Cin=1.
  - 001 ROR: rotate a right by sh.
  - 010 ROL: rotate a left by sh.
  - 011 SLL: a << sh, zero fill.
  - 100 SRL: a >> sh, zero fill.
  - 101 AND: a & b (ANDN via invB).
  - 110 OR: a | b.
  - 111 XOR: a ^ b.
- Ofl, ADD only:
  - sign=1: set when a[15]==b[15] and Out[15]!=a[15].
  - sign=0: set to carry-out of bit 15.
  - All other Ops: Ofl = 0.
- Flags always derive from Out, interpreted as two's complement regardless of sign or Op.
  - Exactly one of zf/gzf/lzf is 1.
  - nezf = ~zf.
- Cin and sign are ignored for non-ADD Ops.
- No X propagation from unused inputs: output must be fully determined by the used inputs.

## Timing
- Out, Ofl, zf, gzf, lzf and nezf are purely combinational: zero-cycle latency, valid within the same evaluation as the inputs.
- Out_r, Ofl_r and flags_r capture the combinational values on every rising clk edge (1-cycle latency). There is no enable and no handshake.
- rst asserted (asynchronous, any time, including mid-operation): Out_r=16'h0000, Ofl_r=0, flags_r=4'b0000 immediately. Registers resume capturing on the first rising edge after rst deasserts.
- Combinational outputs are unaffected by rst.

## Test plan
- Zero add: A=0, B=0, Cin=0, Op=000, inv=0, sign=0 -> Out=0000; zf=1, gzf=0, lzf=0, nezf=0; Ofl=0.
- Add / subtract:
  - A=0, B=0005, Op=000 -> Out=0005; gzf=1, nezf=1.
  - A=0005, B=000A, invB=1, Cin=1, sign=1, Op=000 -> Out=FFFB; lzf=1, nezf=1; Ofl=0.
- Rotate right:
  - A=000A, B=0007, Op=001 -> Out=1400; gzf=1.
  - A=A00A, B=0004 -> Out=AA00; lzf=1.
  - A=8ABD, B=0008 -> Out=BD8A; lzf=1.
- Overflow:
  - sign=1, A=7FFF, B=0001, Op=000 -> Out=8000, Ofl=1.
  - sign=0, A=FFFF, B=0001 -> Out=0000, Ofl=1, zf=1.
  - sign=0, A=7FFF, B=0001 -> Ofl=0.
- Shifts and logic:
  - A=8001, B=0001: ROL -> 0003, SLL -> 0002, SRL -> 4000.
  - A=F0F0, B=FF00: AND -> F000, OR -> FFF0, XOR -> 0FF0.
  - AND with invB=1 -> 00F0.
- Registers and reset:
  - Drive A=0005, B=0005, Op=000, then clock -> Out_r=000A, flags_r=4'b1010.
  - Assert rst between edges -> Out_r=0000, flags_r=0000 immediately; combinational Out stays 000A.

Source files
------------

// File: rtl/alu_unpipelined.sv
`default_nettype none
// ============================================================================
// Module      : alu_unpipelined
// Description : 16-bit single-cycle ALU with condition flags and a registered
//               copy of result, overflow and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_unpipelined (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    input  logic [2:0]  Op,
    input  logic        invA,
    input  logic        invB,
    input  logic        sign,
    output logic [15:0] Out,
    output logic        Ofl,
    output logic        zf,
    output logic        gzf,
    output logic        lzf,
    output logic        nezf,
    output logic [15:0] Out_r,
    output logic        Ofl_r,
    output logic [3:0]  flags_r
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    logic [15:0] a_w;
    logic [15:0] b_w;
    logic [3:0]  sh_w;
    logic [16:0] sum_w;
    logic [31:0] ror_w;
    logic [31:0] rol_w;

    logic [15:0] out_q;
    logic        ofl_q;
    logic [3:0]  flags_q;
    logic [3:0]  flags_d;

    assign a_w   = invA ? ~A : A;
    assign b_w   = invB ? ~B : B;
    assign sh_w  = b_w[3:0];
    assign sum_w = {1'b0, a_w} + {1'b0, b_w} + {16'h0000, Cin};
    // Rotates are shifts of the operand concatenated with itself.
    assign ror_w = {a_w, a_w} >> sh_w;
    assign rol_w = {a_w, a_w} << sh_w;

    always_comb begin
        Out = 16'h0000;
        Ofl = 1'b0;
        case (Op)
            OP_ADD: begin
                Out = sum_w[15:0];
                if (sign)
                    Ofl = (a_w[15] == b_w[15]) && (sum_w[15] != a_w[15]);
                else
                    Ofl = sum_w[16];
            end
            OP_ROR:  Out = ror_w[15:0];
            OP_ROL:  Out = rol_w[31:16];
            OP_SLL:  Out = a_w << sh_w;
            OP_SRL:  Out = a_w >> sh_w;
            OP_AND:  Out = a_w & b_w;
            OP_OR:   Out = a_w | b_w;
            OP_XOR:  Out = a_w ^ b_w;
            default: Out = 16'h0000;
        endcase
    end

    assign zf      = (Out == 16'h0000);
    assign lzf     = Out[15];
    assign gzf     = ~Out[15] & ~zf;
    assign nezf    = ~zf;
    assign flags_d = {nezf, lzf, gzf, zf};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= 16'h0000;
            ofl_q   <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            out_q   <= Out;
            ofl_q   <= Ofl;
            flags_q <= flags_d;
        end
    end

    assign Out_r   = out_q;
    assign Ofl_r   = ofl_q;
    assign flags_r = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_unpipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_unpipelined
// Description : Self-checking bench for alu_unpipelined (vector table,
//               random vectors against a bit-level model, reset sequence).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_unpipelined;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [2:0]  Op;
    logic        invA;
    logic        invB;
    logic        sign;
    logic [15:0] Out;
    logic        Ofl;
    logic        zf;
    logic        gzf;
    logic        lzf;
    logic        nezf;
    logic [15:0] Out_r;
    logic        Ofl_r;
    logic [3:0]  flags_r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [2:0]  op;
        logic        inva;
        logic        invb;
        logic        sgn;
        logic [15:0] eout;
        logic        eofl;
        logic [3:0]  eflg;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic        ofl;
        logic [3:0]  flg;
    } exp_t;

    vec_t tv[$];
    exp_t comb_q[$];
    exp_t reg_q[$];

    alu_unpipelined dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Op(Op),
        .invA(invA), .invB(invB), .sign(sign),
        .Out(Out), .Ofl(Ofl), .zf(zf), .gzf(gzf), .lzf(lzf), .nezf(nezf),
        .Out_r(Out_r), .Ofl_r(Ofl_r), .flags_r(flags_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_of(input logic [15:0] o);
        logic z;
        z = (o == 16'h0000);
        return {!z, o[15], (!o[15] && !z), z};
    endfunction

    // Bit-serial reference model: rotates/shifts one position at a time.
    function automatic logic [16:0] model(input vec_t v);
        logic [15:0] a, b, r;
        logic [16:0] s;
        logic        of;
        a  = v.inva ? ~v.a : v.a;
        b  = v.invb ? ~v.b : v.b;
        r  = 16'h0000;
        of = 1'b0;
        case (v.op)
            3'd0: begin
                s = 17'(a) + 17'(b) + 17'(v.cin);
                r = s[15:0];
                of = v.sgn ? ((a[15] == b[15]) && (r[15] != a[15])) : s[16];
            end
            3'd1: begin r = a; for (int i = 0; i < int'(b[3:0]); i++) r = {r[0], r[15:1]}; end
            3'd2: begin r = a; for (int i = 0; i < int'(b[3:0]); i++) r = {r[14:0], r[15]}; end
            3'd3: begin r = a; for (int i = 0; i < int'(b[3:0]); i++) r = {r[14:0], 1'b0}; end
            3'd4: begin r = a; for (int i = 0; i < int'(b[3:0]); i++) r = {1'b0, r[15:1]}; end
            3'd5: r = a & b;
            3'd6: r = a | b;
            default: r = a ^ b;
        endcase
        return {of, r};
    endfunction

    task automatic apply(input vec_t v, input string tag);
        exp_t e, got;
        @(negedge clk);
        A = v.a; B = v.b; Cin = v.cin; Op = v.op;
        invA = v.inva; invB = v.invb; sign = v.sgn;
        e.out = v.eout; e.ofl = v.eofl; e.flg = v.eflg;
        comb_q.push_back(e);
        reg_q.push_back(e);
        #1;
        got = comb_q.pop_front();
        chk({tag, " Out"},   32'(Out), 32'(got.out));
        chk({tag, " Ofl"},   32'(Ofl), 32'(got.ofl));
        chk({tag, " flags"}, 32'({nezf, lzf, gzf, zf}), 32'(got.flg));
        @(posedge clk);
        #1;
        got = reg_q.pop_front();
        chk({tag, " Out_r"},   32'(Out_r),   32'(got.out));
        chk({tag, " Ofl_r"},   32'(Ofl_r),   32'(got.ofl));
        chk({tag, " flags_r"}, 32'(flags_r), 32'(got.flg));
    endtask

    initial begin
        vec_t v;
        logic [16:0] m;

        //              a        b        cin   op   inA   inB   sgn   eout     ofl   flags
        tv.push_back('{16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0001});
        tv.push_back('{16'h0000, 16'h0005, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 4'b1010});
        tv.push_back('{16'h0005, 16'h000A, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 16'hFFFB, 1'b0, 4'b1100});
        tv.push_back('{16'h000A, 16'h0007, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 16'h1400, 1'b0, 4'b1010});
        tv.push_back('{16'hA00A, 16'h0004, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 16'hAA00, 1'b0, 4'b1100});
        tv.push_back('{16'h8ABD, 16'h0008, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 16'hBD8A, 1'b0, 4'b1100});
        tv.push_back('{16'h7FFF, 16'h0001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 4'b1100});
        tv.push_back('{16'hFFFF, 16'h0001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001});
        tv.push_back('{16'h7FFF, 16'h0001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 4'b1100});
        tv.push_back('{16'h8001, 16'h0001, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 4'b1010});
        tv.push_back('{16'h8001, 16'h0001, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 4'b1010});
        tv.push_back('{16'h8001, 16'h0001, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 16'h4000, 1'b0, 4'b1010});
        tv.push_back('{16'hF0F0, 16'hFF00, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 16'hF000, 1'b0, 4'b1100});
        tv.push_back('{16'hF0F0, 16'hFF00, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 16'hFFF0, 1'b0, 4'b1100});
        tv.push_back('{16'hF0F0, 16'hFF00, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 16'h0FF0, 1'b0, 4'b1010});
        tv.push_back('{16'hF0F0, 16'hFF00, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 16'h00F0, 1'b0, 4'b1010});
        tv.push_back('{16'h0000, 16'h0001, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001});
        tv.push_back('{16'h00FF, 16'h00FF, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 4'b0001});
        tv.push_back('{16'h1234, 16'h0010, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 4'b1010});
        tv.push_back('{16'h8000, 16'h000F, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 4'b1010});
        tv.push_back('{16'h0001, 16'hF00F, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 4'b1010});
        tv.push_back('{16'h8000, 16'hFFFF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1, 4'b1010});

        rst = 1'b1; A = '0; B = '0; Cin = 0; Op = '0; invA = 0; invB = 0; sign = 0;
        #2;
        chk("reset Out_r",   32'(Out_r),   32'h0);
        chk("reset Ofl_r",   32'(Ofl_r),   32'h0);
        chk("reset flags_r", 32'(flags_r), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) apply(tv[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            v.a = 16'($urandom); v.b = 16'($urandom);
            v.cin = 1'($urandom); v.op = 3'($urandom);
            v.inva = 1'($urandom); v.invb = 1'($urandom); v.sgn = 1'($urandom);
            m = model(v);
            v.eout = m[15:0]; v.eofl = m[16]; v.eflg = flags_of(m[15:0]);
            apply(v, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset between edges, then recovery.
        v = '{16'h0005, 16'h0005, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h000A, 1'b0, 4'b1010};
        apply(v, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        chk("async rst Out_r",   32'(Out_r),   32'h0);
        chk("async rst Ofl_r",   32'(Ofl_r),   32'h0);
        chk("async rst flags_r", 32'(flags_r), 32'h0);
        chk("async rst Out",     32'(Out),     32'h000A);
        chk("async rst nezf",    32'(nezf),    32'h1);
        @(posedge clk);
        #1;
        chk("held rst Out_r", 32'(Out_r), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post rst Out_r", 32'(Out_r), 32'h0);
        @(posedge clk);
        #1;
        chk("resume Out_r",   32'(Out_r),   32'h000A);
        chk("resume flags_r", 32'(flags_r), 32'hA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
